conv_engine_param: RTL

Parametrised streaming 2-D convolution engine: the successor to the fixed 5×5, stride-1 engine. It accepts a raster-order 8-bit pixel stream over a valid/ready handshake and builds a K×K window internally. A registered multiply/adder tree adds a per-map bias to each window result and writes one signed result per output position to the feature-map BRAM. It sits between the input pixel DMA and the output BRAM. Additions over the previous engine: configurable kernel size and stride, rectangular maps, bias, optional ReLU, and full write-side backpressure.

---
 rtl/conv_engine_param.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/conv_engine_param.sv
// conv_engine_param: streaming K x K 2-D convolution with stride, bias and
// write-side backpressure. Pixels arrive in raster order; one signed result
// per output position is written to the feature-map BRAM in raster order.
// Build option: define CONV_RELU_EN to clamp each result to max(0, sum+bias).
//
// Handshakes: an input transfer happens on a clock edge where
// data_valid_in && data_ready; a write transfer happens on an edge where
// mem_wr_en && mem_wr_ready. While a write is offered but not accepted
// (stall) the write bus is held and the whole engine freezes.
//
// Weight packing: element (i,j) of the kernel (row i, column j, row-major
// index i*K+j) sits at weights[(i*K+j)*8 +: 8]; element 0 is the top-left tap.
module conv_engine_param #(
  parameter int MAP_W  = 32,
  parameter int MAP_H  = 32,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int ACC_W  = 32,
  localparam int OUT_W = (MAP_W - K) / STRIDE + 1,
  localparam int OUT_H = (MAP_H - K) / STRIDE + 1,
  localparam int AW    = ($clog2(OUT_W * OUT_H) > 0) ? $clog2(OUT_W * OUT_H) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               data_valid_in,
  output logic               data_ready,
  input  logic [7:0]         pixel_in,
  input  logic [K*K*8-1:0]   weights,
  input  logic [ACC_W-1:0]   bias,
  output logic [AW-1:0]      mem_wr_addr,
  output logic [ACC_W-1:0]   mem_wr_data,
  output logic               mem_wr_en,
  input  logic               mem_wr_ready,
  output logic               all_done,
  output logic [1:0]         dbg_state
);

  localparam int CW      = $clog2(MAP_W);
  localparam int RW      = $clog2(MAP_H);
  localparam int PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int COL_MAX = (OUT_W - 1) * STRIDE + K - 1;
  localparam int ROW_MAX = (OUT_H - 1) * STRIDE + K - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic          stall, adv, in_xfer, last_px, emit, pipe_empty;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [PW-1:0] col_ph_q, row_ph_q;
  logic          v0_q, v1_q, v2_q, v3_q;

  logic        [7:0]       lb_q   [K-1][MAP_W];
  logic        [7:0]       colv   [K];
  logic signed [7:0]       win_q  [K][K];
  logic signed [7:0]       wgt    [K][K];
  logic signed [15:0]      prod_q [K][K];
  logic        [ACC_W-1:0] rsum   [K];
  logic        [ACC_W-1:0] psum_q [K];
  logic        [ACC_W-1:0] total, sum_q, res;

  // An unaccepted write freezes every stage so nothing is lost or duplicated.
  assign stall      = mem_wr_en && !mem_wr_ready;
  assign adv        = !stall;
  assign data_ready = (state_q == S_STREAM) && !stall;
  assign in_xfer    = data_valid_in && data_ready;
  assign all_done   = (state_q == S_DONE);
  assign dbg_state  = state_q;
  assign pipe_empty = !(v0_q || v1_q || v2_q || v3_q || mem_wr_en);
  assign last_px    = (row_q == RW'(MAP_H - 1)) && (col_q == CW'(MAP_W - 1));

  // The accepted pixel completes a window on the stride grid inside the map.
  assign emit = (col_q >= CW'(K - 1)) && (col_q <= CW'(COL_MAX)) && (col_ph_q == '0) &&
                (row_q >= RW'(K - 1)) && (row_q <= RW'(ROW_MAX)) && (row_ph_q == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: stream the frame, drain the pipeline, pulse done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (in_xfer && last_px) state_d = S_FLUSH;
      S_FLUSH:  if (pipe_empty) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Position, stride-phase and write-address counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      mem_wr_addr <= '0;
    end else if (state_q == S_IDLE && start) begin
      col_q       <= '0;
      row_q       <= '0;
      col_ph_q    <= '0;
      row_ph_q    <= '0;
      mem_wr_addr <= '0;
    end else begin
      if (in_xfer) begin
        if (col_q == CW'(MAP_W - 1)) begin
          col_q    <= '0;
          col_ph_q <= '0;
          row_q    <= row_q + RW'(1);
          if (row_q >= RW'(K - 1))
            row_ph_q <= (row_ph_q == PW'(STRIDE - 1)) ? '0 : row_ph_q + PW'(1);
        end else begin
          col_q <= col_q + CW'(1);
          if (col_q >= CW'(K - 1))
            col_ph_q <= (col_ph_q == PW'(STRIDE - 1)) ? '0 : col_ph_q + PW'(1);
        end
      end
      if (mem_wr_en && mem_wr_ready) mem_wr_addr <= mem_wr_addr + AW'(1);
    end
  end

  // Pipeline valid bits and the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else if (adv) begin
      v0_q      <= in_xfer && emit;
      v1_q      <= v0_q;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      mem_wr_en <= v3_q;
      if (v3_q) mem_wr_data <= res;
    end
  end

  // Combinational datapath: kernel unpack, column feed, row sums, final sum.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) wgt[i][j] = weights[(i*K+j)*8 +: 8];
    end
    for (int i = 0; i < K - 1; i++) colv[i] = lb_q[K-2-i][col_q];
    colv[K-1] = pixel_in;
    for (int i = 0; i < K; i++) begin
      rsum[i] = '0;
      for (int j = 0; j < K; j++) rsum[i] = rsum[i] + ACC_W'(prod_q[i][j]);
    end
    total = bias;
    for (int i = 0; i < K; i++) total = total + psum_q[i];
`ifdef CONV_RELU_EN
    res = sum_q[ACC_W-1] ? '0 : sum_q;
`else
    res = sum_q;
`endif
  end

  // Line buffers and window shift on input transfers; arithmetic stages on advance.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb_q[0][col_q] <= pixel_in;
      for (int j = 1; j < K - 1; j++) lb_q[j][col_q] <= lb_q[j-1][col_q];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= colv[i];
      end
    end
    if (adv) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) prod_q[i][j] <= 16'(win_q[i][j]) * 16'(wgt[i][j]);
        psum_q[i] <= rsum[i];
      end
      sum_q <= total;
    end
  end

endmodule
